// File: rtl/adc_vol_averager.sv
// Paces ADC081C021 reads with a periodic trigger, averages 2^avg_log2 samples and
// converts the mean code to millivolts. Flags a driver that never answers.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | waiting for a rate tick; window cleared while enable is low
// ST_TRIG | read_trigger high this cycle, timeout timer loaded
// ST_WAIT | waiting for read_done or timeout
// ST_DONE | window complete: publish mean code, mV value and valid pulse
module adc_vol_averager #(
    parameter int unsigned sys_clk_freq   = 50_000_000,
    parameter int unsigned sample_rate    = 10_000,
    parameter int unsigned avg_log2       = 3,
    parameter int unsigned vref_mv        = 3300,
    parameter int unsigned timeout_cycles = 10_000
) (
    input  logic        sclk,
    input  logic        rst,
    input  logic        enable,
    output logic        read_trigger,
    input  logic        read_done,
    input  logic [7:0]  voltage,
    output logic [7:0]  avg_code,
    output logic [15:0] avg_mv,
    output logic        avg_valid,
    output logic        timeout_err,
    output logic [8:0]  sample_cnt
);

    localparam int unsigned PERIOD = sys_clk_freq / sample_rate;
    localparam int unsigned RATE_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int unsigned TO_W   = (timeout_cycles > 1) ? $clog2(timeout_cycles) : 1;
    localparam int unsigned ACC_W  = 8 + avg_log2;

    localparam logic [RATE_W-1:0] RATE_LAST = RATE_W'(PERIOD - 1);
    localparam logic [TO_W-1:0]   TO_LOAD   = TO_W'(timeout_cycles - 1);
    localparam logic [8:0]        WIN_LAST  = 9'((1 << avg_log2) - 1);
    localparam logic [15:0]       VREF      = 16'(vref_mv);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TRIG,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [RATE_W-1:0]  rate_cnt_q, rate_cnt_d;
    logic               tick_q, tick_d;
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [8:0]         cnt_q, cnt_d;
    logic               read_trigger_q, read_trigger_d;
    logic               avg_valid_q, avg_valid_d;
    logic [7:0]         avg_code_q, avg_code_d;
    logic [15:0]        avg_mv_q, avg_mv_d;
    logic               timeout_err_q, timeout_err_d;

    always_comb begin
        state_d        = state_q;
        rate_cnt_d     = rate_cnt_q;
        tick_d         = 1'b0;
        to_cnt_d       = to_cnt_q;
        acc_d          = acc_q;
        cnt_d          = cnt_q;
        read_trigger_d = 1'b0;
        avg_valid_d    = 1'b0;
        avg_code_d     = avg_code_q;
        avg_mv_d       = avg_mv_q;
        timeout_err_d  = timeout_err_q;

        if (!enable) begin
            rate_cnt_d = '0;
        end else if (rate_cnt_q == RATE_LAST) begin
            rate_cnt_d = '0;
            tick_d     = 1'b1;
        end else begin
            rate_cnt_d = rate_cnt_q + RATE_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (!enable) begin
                    acc_d = '0;
                    cnt_d = '0;
                end else if (tick_q) begin
                    state_d        = ST_TRIG;
                    read_trigger_d = 1'b1;
                end
            end
            ST_TRIG: begin
                to_cnt_d = TO_LOAD;
                if (enable) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end
            ST_WAIT: begin
                // The driver transaction always finishes, so a disable only takes effect here.
                if (read_done) begin
                    state_d = ST_IDLE;
                    if (!enable) begin
                        acc_d = '0;
                        cnt_d = '0;
                    end else if (cnt_q == WIN_LAST) begin
                        acc_d   = acc_q + ACC_W'(voltage);
                        cnt_d   = '0;
                        state_d = ST_DONE;
                    end else begin
                        acc_d = acc_q + ACC_W'(voltage);
                        cnt_d = cnt_q + 9'd1;
                    end
                end else if (to_cnt_q == '0) begin
                    state_d = ST_IDLE;
                    if (enable) begin
                        timeout_err_d = 1'b1;
                    end else begin
                        acc_d = '0;
                        cnt_d = '0;
                    end
                end else begin
                    to_cnt_d = to_cnt_q - TO_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                acc_d   = '0;
                cnt_d   = '0;
                if (enable) begin
                    avg_code_d  = acc_q[ACC_W-1 -: 8];
                    avg_mv_d    = 16'((24'(avg_code_d) * 24'(VREF)) >> 8);
                    avg_valid_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (!enable) begin
            timeout_err_d = 1'b0;
        end
    end

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            rate_cnt_q     <= '0;
            tick_q         <= 1'b0;
            to_cnt_q       <= '0;
            acc_q          <= '0;
            cnt_q          <= '0;
            read_trigger_q <= 1'b0;
            avg_valid_q    <= 1'b0;
            avg_code_q     <= '0;
            avg_mv_q       <= '0;
            timeout_err_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            rate_cnt_q     <= rate_cnt_d;
            tick_q         <= tick_d;
            to_cnt_q       <= to_cnt_d;
            acc_q          <= acc_d;
            cnt_q          <= cnt_d;
            read_trigger_q <= read_trigger_d;
            avg_valid_q    <= avg_valid_d;
            avg_code_q     <= avg_code_d;
            avg_mv_q       <= avg_mv_d;
            timeout_err_q  <= timeout_err_d;
        end
    end

    assign read_trigger = read_trigger_q;
    assign avg_valid    = avg_valid_q;
    assign avg_code     = avg_code_q;
    assign avg_mv       = avg_mv_q;
    assign timeout_err  = timeout_err_q;
    assign sample_cnt   = cnt_q;

endmodule

// File: tb/tb_adc_vol_averager.sv
// Bench for adc_vol_averager: instance 0 averages 8 samples at 3300 mV, instance 1
// passes single samples through at 5000 mV; both run with a 100-cycle period.
module tb_adc_vol_averager;

    localparam int P    = 100;
    localparam int T    = 60;
    localparam int SYS  = 1_000_000;
    localparam int RATE = 10_000;

    logic        sclk;
    logic        rst;
    logic        en    [2];
    logic        rd    [2];
    logic [7:0]  volt  [2];
    logic        trig  [2];
    logic [7:0]  code  [2];
    logic [15:0] mv    [2];
    logic        vld   [2];
    logic        terr  [2];
    logic [8:0]  scnt  [2];

    int cyc;
    int nchk;
    int nerr;

    int nwin      [2];
    int vref      [2];
    int win_sum   [2];
    int win_n     [2];
    int exp_code  [2];
    int exp_mv    [2];
    int exp_err   [2];
    int prev_trig [2];

    adc_vol_averager #(
        .sys_clk_freq(SYS), .sample_rate(RATE), .avg_log2(3),
        .vref_mv(3300), .timeout_cycles(T)
    ) u_dut_a (
        .sclk(sclk), .rst(rst), .enable(en[0]), .read_trigger(trig[0]),
        .read_done(rd[0]), .voltage(volt[0]), .avg_code(code[0]), .avg_mv(mv[0]),
        .avg_valid(vld[0]), .timeout_err(terr[0]), .sample_cnt(scnt[0])
    );

    adc_vol_averager #(
        .sys_clk_freq(SYS), .sample_rate(RATE), .avg_log2(0),
        .vref_mv(5000), .timeout_cycles(T)
    ) u_dut_b (
        .sclk(sclk), .rst(rst), .enable(en[1]), .read_trigger(trig[1]),
        .read_done(rd[1]), .voltage(volt[1]), .avg_code(code[1]), .avg_mv(mv[1]),
        .avg_valid(vld[1]), .timeout_err(terr[1]), .sample_cnt(scnt[1])
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    initial cyc = 0;
    always @(posedge sclk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running after 200000 cycles");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nchk++;
        assert (obs === expv) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic wait_trig(input int sel, input int budget, output int elapsed);
        int  t0;
        bit  found;
        t0    = cyc;
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge sclk);
            if (trig[sel] === 1'b1) found = 1'b1;
        end
        nchk++;
        assert (found) else begin
            nerr++;
            $error("FAIL trig_wait[%0d]: observed none expected read_trigger within %0d cycles", sel, budget);
        end
        elapsed = cyc - t0;
    endtask

    // Reference: mean of the completed window, then code * vref / 256.
    task automatic model_sample(input int sel, input int v, output bit fin);
        win_sum[sel] += v;
        win_n[sel]++;
        fin = (win_n[sel] == nwin[sel]);
        if (fin) begin
            exp_code[sel] = win_sum[sel] / nwin[sel];
            exp_mv[sel]   = (exp_code[sel] * vref[sel]) / 256;
            win_sum[sel]  = 0;
            win_n[sel]    = 0;
        end
    endtask

    // first=1: the call is made in the cycle enable rose; expect the trigger P+1 cycles later.
    task automatic do_sample(input int sel, input logic [7:0] v, input int lat, input bit first);
        int el;
        bit fin;
        wait_trig(sel, 3 * P, el);
        if (first) chk("first_trig_delay", el, P + 1);
        else       chk("trig_period", cyc - prev_trig[sel], P);
        prev_trig[sel] = cyc;
        @(negedge sclk);
        chk("trig_width", trig[sel], 0);
        repeat (lat - 1) @(negedge sclk);
        rd[sel]   = 1'b1;
        volt[sel] = v;
        @(negedge sclk);
        rd[sel]   = 1'b0;
        volt[sel] = 8'($urandom);
        model_sample(sel, int'(v), fin);
        chk("sample_cnt", scnt[sel], win_n[sel]);
        @(negedge sclk);
        chk("avg_valid", vld[sel], fin);
        chk("avg_code", code[sel], exp_code[sel]);
        chk("avg_mv", mv[sel], exp_mv[sel]);
        chk("timeout_err", terr[sel], exp_err[sel]);
        @(negedge sclk);
        chk("avg_valid_pulse", vld[sel], 0);
    endtask

    task automatic no_answer(input int sel);
        int el;
        int t0;
        bit seen;
        wait_trig(sel, 3 * P, el);
        chk("trig_period", cyc - prev_trig[sel], P);
        prev_trig[sel] = cyc;
        t0   = cyc;
        seen = 1'b0;
        for (int i = 0; i < 2 * T && !seen; i++) begin
            @(negedge sclk);
            if (terr[sel] === 1'b1) seen = 1'b1;
        end
        chk("timeout_delay", cyc - t0, T + 1);
        chk("timeout_cnt_kept", scnt[sel], win_n[sel]);
        exp_err[sel] = 1;
    endtask

    initial begin
        int  el;
        bit  any_trig;
        bit  any_vld;
        logic [7:0] v;

        nchk = 0;
        nerr = 0;
        nwin = '{8, 1};
        vref = '{3300, 5000};
        for (int s = 0; s < 2; s++) begin
            en[s] = 1'b0; rd[s] = 1'b0; volt[s] = 8'd0;
            win_sum[s] = 0; win_n[s] = 0; exp_code[s] = 0; exp_mv[s] = 0;
            exp_err[s] = 0; prev_trig[s] = 0;
        end
        rst = 1'b1;
        repeat (3) @(negedge sclk);
        for (int s = 0; s < 2; s++) begin
            chk("rst_trig", trig[s], 0);
            chk("rst_valid", vld[s], 0);
            chk("rst_code", code[s], 0);
            chk("rst_mv", mv[s], 0);
            chk("rst_err", terr[s], 0);
            chk("rst_cnt", scnt[s], 0);
        end
        rst = 1'b0;
        repeat (2) @(negedge sclk);

        // Four windows: constant 128, alternating 0/255, constant 255, random.
        en[0] = 1'b1;
        for (int w = 0; w < 4; w++) begin
            for (int i = 0; i < 8; i++) begin
                case (w)
                    0:       v = 8'd128;
                    1:       v = (i % 2 == 1) ? 8'd255 : 8'd0;
                    2:       v = 8'd255;
                    default: v = 8'($urandom_range(0, 255));
                endcase
                do_sample(0, v, (w == 3 && i == 2) ? T : $urandom_range(1, T - 1),
                          (w == 0 && i == 0));
            end
        end

        // Silent driver mid-window, then keep the window going.
        for (int i = 0; i < 3; i++) do_sample(0, 8'($urandom), $urandom_range(1, T - 1), 1'b0);
        no_answer(0);
        for (int i = 0; i < 2; i++) do_sample(0, 8'($urandom), $urandom_range(1, T - 1), 1'b0);

        // Disable while a read is outstanding after 5 samples.
        wait_trig(0, 3 * P, el);
        chk("trig_period", cyc - prev_trig[0], P);
        @(negedge sclk);
        en[0] = 1'b0;
        repeat (5) @(negedge sclk);
        chk("dis_wait_cnt", scnt[0], 5);
        chk("dis_err_clear", terr[0], 0);
        exp_err[0] = 0;
        rd[0]   = 1'b1;
        volt[0] = 8'($urandom);
        @(negedge sclk);
        rd[0] = 1'b0;
        win_sum[0] = 0;
        win_n[0]   = 0;
        chk("dis_cnt_cleared", scnt[0], 0);
        any_trig = 1'b0;
        any_vld  = 1'b0;
        for (int i = 0; i < 2 * P; i++) begin
            @(negedge sclk);
            if (trig[0] !== 1'b0) any_trig = 1'b1;
            if (vld[0] !== 1'b0) any_vld = 1'b1;
        end
        chk("dis_no_trig", any_trig, 0);
        chk("dis_no_valid", any_vld, 0);
        chk("dis_code_hold", code[0], exp_code[0]);
        chk("dis_mv_hold", mv[0], exp_mv[0]);
        en[0] = 1'b1;
        do_sample(0, 8'($urandom), $urandom_range(1, T - 1), 1'b1);
        do_sample(0, 8'($urandom), $urandom_range(1, T - 1), 1'b0);
        no_answer(0);

        // Reset in the middle of a wait; a late read_done must be ignored.
        wait_trig(0, 3 * P, el);
        chk("trig_period", cyc - prev_trig[0], P);
        @(negedge sclk);
        rst = 1'b1;
        #1;
        chk("midrst_trig", trig[0], 0);
        chk("midrst_valid", vld[0], 0);
        chk("midrst_code", code[0], 0);
        chk("midrst_mv", mv[0], 0);
        chk("midrst_err", terr[0], 0);
        chk("midrst_cnt", scnt[0], 0);
        win_sum[0] = 0; win_n[0] = 0; exp_code[0] = 0; exp_mv[0] = 0; exp_err[0] = 0;
        @(negedge sclk);
        rst     = 1'b0;
        rd[0]   = 1'b1;
        volt[0] = 8'd77;
        @(negedge sclk);
        rd[0] = 1'b0;
        en[0] = 1'b0;
        chk("late_done_cnt", scnt[0], 0);
        @(negedge sclk);
        chk("late_done_valid", vld[0], 0);
        en[0] = 1'b1;
        for (int i = 0; i < 8; i++)
            do_sample(0, 8'($urandom), $urandom_range(1, T - 1), (i == 0));
        en[0] = 1'b0;

        // Window of one: every sample publishes itself.
        @(negedge sclk);
        en[1] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            case (i)
                0:       v = 8'd0;
                1:       v = 8'd255;
                default: v = 8'($urandom_range(0, 255));
            endcase
            do_sample(1, v, $urandom_range(1, T - 1), (i == 0));
        end
        en[1] = 1'b0;
        @(negedge sclk);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/adc_vol_averager.md
# adc_vol_averager

Downstream consumer and pacing master for the ADC081C021 read driver. It issues a periodic one-cycle `read_trigger` to the driver and captures each 8-bit `voltage` code on `read_done`. It averages 2^`avg_log2` consecutive samples and presents the mean code plus a millivolt conversion with a one-cycle valid strobe. It also detects a driver that never answers.

## Interface

- `sys_clk_freq`, 50_000_000: clock frequency in Hz.
- `sample_rate`, 10_000: trigger rate in Hz.
  - Period P = `sys_clk_freq`/`sample_rate` cycles; the default gives P = 5000.
  - P must exceed one driver read (~3563 cycles at 400 kHz I2C, 50 MHz).
- `avg_log2`, 3: log2 of the window length N. Legal 0..8; the default gives N = 8.
- `vref_mv`, 3300: ADC reference in mV, 1..65535.
- `timeout_cycles`, 10_000: maximum cycles spent waiting for `read_done` after a trigger.

Ports (clock and reset first):

- `sclk`  in  1: system clock. One clock domain; reset is asynchronous and active-high.
- `rst`  in  1: asynchronous, active-high reset.
- `enable`  in  1: level. Enables sampling; low stops sampling and clears the window.
- `read_trigger`  out  1: one-cycle pulse to the driver's trigger input.
- `read_done`  in  1: one-cycle pulse from the driver.
- `voltage`  in  8: driver result. Valid in the cycle `read_done` is high.
- `avg_code`  out  8: mean code of the last completed window.
- `avg_mv`  out  16: `avg_code` converted to mV.
- `avg_valid`  out  1: one-cycle pulse when `avg_code` and `avg_mv` update.
- `timeout_err`  out  1: sticky flag, set when a read times out.
- `sample_cnt`  out  9: number of samples in the current window, 0..N-1.

## Operation

- Rate counter:
  - Counts 0..P-1 while `enable` is high and generates `tick` at P-1.
  - Held at 0 while `enable` is low, so the first tick comes P cycles after `enable` rises.
- State machine: IDLE, TRIG, WAIT, DONE.
  - IDLE: on `tick` with `enable` high, go to TRIG.
  - TRIG: `read_trigger` = 1 for exactly this cycle, the timeout counter is cleared, and the next state is WAIT.
  - WAIT, `read_done` arrives:
    - Add `voltage` (zero-extended) to the accumulator (width 8+`avg_log2`) and increment `sample_cnt`.
    - If this was sample N, go to DONE; otherwise go to IDLE.
  - WAIT, no answer: if the timeout counter reaches `timeout_cycles`, set `timeout_err`, go to IDLE and leave the accumulator and count unchanged.
  - DONE:
    - `avg_code` = accumulator >> `avg_log2` (truncating).
    - `avg_mv` = bits [23:8] of the 24-bit product `avg_code`×`vref_mv` (truncating divide by 256).
    - Pulse `avg_valid`, clear the accumulator and `sample_cnt`, and go to IDLE.
- Ticks arriving outside IDLE are dropped, never queued.
- `read_done` arriving outside WAIT is ignored.
- `enable` falls:
  - Outside WAIT: go to IDLE next cycle and clear the accumulator and `sample_cnt`.
  - In WAIT: stay until `read_done` or timeout (the driver transaction always completes), discard that sample, then go to IDLE cleared.
  - `timeout_err` clears while `enable` is low.
  - `avg_code` and `avg_mv` hold their last value.
- `avg_log2` = 0: every sample completes a window; `avg_code` equals `voltage`.

## Timing

- Reset values: `read_trigger` 0, `avg_valid` 0, `avg_code` 0, `avg_mv` 0, `timeout_err` 0, `sample_cnt` 0, state IDLE, rate counter 0.
- `tick` at edge t → TRIG at edge t+1 → `read_trigger` high for the cycle after edge t+1.
- `read_done` high is sampled at edge k: the accumulator and `sample_cnt` update at edge k.
- For the final sample of a window, DONE runs in the cycle after edge k. At edge k+1:
  - `avg_code`, `avg_mv` and `avg_valid` register together.
  - `avg_valid` is high for one cycle, and the outputs stay stable until the next window.
- Timeout: `timeout_err` rises exactly `timeout_cycles` cycles after WAIT is entered if no `read_done` has arrived.
- If `read_done` and the timeout fall in the same cycle, `read_done` wins: the sample is accepted and no error is flagged.
- Accumulator overflow is impossible: max N×255 < 2^(8+`avg_log2`).
- `rst` asserted at any point, including mid-WAIT, returns all registers to reset values immediately.

## Test plan

- Default parameters, constant `voltage` = 128 → `read_trigger` every 5000 cycles; after 8 `read_done`, `avg_code` = 128, `avg_mv` = 1650, `avg_valid` high one cycle.
- `voltage` alternating 0/255 over 8 samples → accumulator 1020, `avg_code` = 127, `avg_mv` = 1637.
- `voltage` = 255 constant → `avg_code` = 255, `avg_mv` = 3287; `vref_mv` = 5000 gives 4980.
- Driver never answers:
  - `timeout_err` rises 10_000 cycles after the trigger, and `sample_cnt` is unchanged.
  - The next trigger follows on a later tick.
  - `enable` low clears `timeout_err`.
- `enable` dropped in WAIT after 5 samples → no action until `read_done`, then `sample_cnt` = 0 and no `avg_valid`. Re-enable → the first trigger comes 5000 cycles later.
- `rst` pulsed mid-WAIT → all outputs return to 0 immediately; a late `read_done` is ignored.
